// File: rtl/gear_pkg.sv
// Shared definitions for the 20->100 frame reassembly stage.
//   W_GEAR / N_GEAR : default word width and words per frame
//   phase_t         : word-position counter within a group
//   gear_sync_t     : alignment state (words are dropped until first strobe)
package gear_pkg;
  localparam int W_GEAR  = 20;
  localparam int N_GEAR  = 5;
  localparam int PHASE_W = (N_GEAR > 1) ? $clog2(N_GEAR) : 1;

  typedef bit [PHASE_W-1:0] phase_t;

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } gear_sync_t;
endpackage

// File: rtl/gear20_100.sv
// gear20_100 : collects groups of N W-bit words into one N*W-bit frame.
// Ports:
//   clk, rst      : clock (posedge) and synchronous active-high reset
//   D, D_en       : input word and its live-cycle qualifier
//   D_first       : with D_en, marks word 0 of a group (realigns phase)
//   Q, Q_valid    : assembled frame and its one-deep holding register flag
//   Q_ready       : consumer takes Q on a cycle with Q_valid
//   resync        : one-cycle pulse, strobe arrived mid-group
//   overrun       : sticky, a completed frame found the holding reg full
module gear20_100
  import gear_pkg::*;
#(
  parameter int W         = W_GEAR,
  parameter int N         = N_GEAR,
  parameter bit FIRST_LSB = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   D,
  input  logic           D_en,
  input  logic           D_first,
  output logic [N*W-1:0] Q,
  output logic           Q_valid,
  input  logic           Q_ready,
  output logic           resync,
  output logic           overrun
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  gear_sync_t     state_q,   state_d;
  logic [PW-1:0]  phase_q,   phase_d;
  logic [N*W-1:0] acc_q,     acc_d;
  logic [N*W-1:0] q_q,       q_d;
  logic           qv_q,      qv_d;
  logic           resync_q,  resync_d;
  logic           overrun_q, overrun_d;

  logic           accept;
  logic           complete;
  logic           free;
  logic [PW-1:0]  wr_phase;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qv_d      = qv_q;
    resync_d  = 1'b0;
    overrun_d = overrun_q;

    // A strobed word is always accepted and always lands in slot 0;
    // unstrobed words count only once aligned.
    accept   = D_en && (D_first || (state_q == SYNC));
    wr_phase = D_first ? '0 : phase_q;
    complete = accept && (wr_phase == PW'(N-1));
    free     = !qv_q || Q_ready;

    if (accept) begin
      for (int s = 0; s < N; s++) begin
        if (wr_phase == PW'(s)) begin
          if (FIRST_LSB) acc_d[s*W +: W]       = D;
          else           acc_d[(N-1-s)*W +: W] = D;
        end
      end
      phase_d = (wr_phase == PW'(N-1)) ? '0 : wr_phase + PW'(1);
    end

    if (D_en && D_first) begin
      state_d = SYNC;
      // Only a strobe that interrupts a partly filled group is a resync.
      if (state_q == SYNC && phase_q != '0) resync_d = 1'b1;
    end

    // acc_d already carries the completing word, so the frame is whole.
    if (complete) begin
      if (free) begin
        q_d  = acc_d;
        qv_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (qv_q && Q_ready) begin
      qv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNSYNC;
      phase_q   <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qv_q      <= 1'b0;
      resync_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qv_q      <= qv_d;
      resync_q  <= resync_d;
      overrun_q <= overrun_d;
    end
  end

  assign Q       = q_q;
  assign Q_valid = qv_q;
  assign resync  = resync_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_gear20_100.sv
module tb_gear20_100;
  localparam int W = 20;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   D = '0;
  logic           D_en = 1'b0;
  logic           D_first = 1'b0;
  logic           Q_ready = 1'b0;
  logic [N*W-1:0] Q;
  logic           Q_valid;
  logic           resync;
  logic           overrun;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  gear20_100 #(.W(W), .N(N), .FIRST_LSB(1'b1)) dut (
    .clk(clk), .rst(rst), .D(D), .D_en(D_en), .D_first(D_first),
    .Q(Q), .Q_valid(Q_valid), .Q_ready(Q_ready),
    .resync(resync), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of words for the group in progress; a frame forms when
  // the queue reaches N entries, packed first word lowest.
  logic [W-1:0]   grp[$];
  bit             m_sync;
  logic [N*W-1:0] m_q, m_fr;
  bit             m_qv, m_rs, m_ov, m_done;

  always @(posedge clk) begin
    if (rst) begin
      grp.delete();
      m_sync = 0; m_q = '0; m_qv = 0; m_rs = 0; m_ov = 0;
    end else begin
      m_rs = 0; m_done = 0; m_fr = '0;
      if (D_en) begin
        if (D_first) begin
          if (m_sync && grp.size() != 0) m_rs = 1;
          grp.delete();
          grp.push_back(D);
          m_sync = 1;
        end else if (m_sync) begin
          grp.push_back(D);
        end
        if (grp.size() == N) begin
          for (int i = 0; i < N; i++) m_fr[i*W +: W] = grp[i];
          grp.delete();
          m_done = 1;
        end
      end
      if (m_done) begin
        if (!m_qv || Q_ready) begin m_q = m_fr; m_qv = 1; end
        else m_ov = 1;
      end else if (m_qv && Q_ready) begin
        m_qv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("Q",       Q,                    m_q);
      chk("Q_valid", {{(N*W-1){1'b0}}, Q_valid}, {{(N*W-1){1'b0}}, m_qv});
      chk("resync",  {{(N*W-1){1'b0}}, resync},  {{(N*W-1){1'b0}}, m_rs});
      chk("overrun", {{(N*W-1){1'b0}}, overrun}, {{(N*W-1){1'b0}}, m_ov});
    end
  end

  // Inputs change on the falling edge; one call spans one rising edge.
  task automatic step(input bit en, input bit first, input logic [W-1:0] d, input bit rdy);
    D_en = en; D_first = first; D = d; Q_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; D_en = 0; D_first = 0; D = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic group(input logic [W-1:0] base, input bit rdy);
    for (int i = 1; i <= N; i++) step(1'b1, i == 1, base + W'(i), rdy);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset Q", Q, '0);
    chk("reset Q_valid", {99'b0, Q_valid}, '0);
    chk("reset overrun", {99'b0, overrun}, '0);

    // 1: basic group, frame one edge after last word
    group(20'h00000, 1'b1);
    chk("t1 Q_valid", {99'b0, Q_valid}, 100'h1);
    chk("t1 Q", Q, 100'h00005_00004_00003_00002_00001);
    step(0, 0, 0, 1);

    // 2: unstrobed words ignored after reset
    do_reset();
    step(1, 0, 20'hAAAAA, 1);
    step(1, 0, 20'hBBBBB, 1);
    step(1, 0, 20'hCCCCC, 1);
    chk("t2 no Q_valid", {99'b0, Q_valid}, '0);
    chk("t2 no resync", {99'b0, resync}, '0);
    group(20'h00010, 1'b1);
    chk("t2 Q", Q, 100'h00015_00014_00013_00012_00011);

    // 3: strobe on third word of a group
    step(1, 1, 20'h00021, 1);
    step(1, 0, 20'h00022, 1);
    step(1, 1, 20'h00031, 1);
    chk("t3 resync", {99'b0, resync}, 100'h1);
    for (int i = 2; i <= 5; i++) step(1, 0, 20'h00030 + W'(i), 1);
    chk("t3 resync cleared", {99'b0, resync}, '0);
    chk("t3 Q", Q, 100'h00035_00034_00033_00032_00031);
    step(0, 0, 0, 1);

    // 4: consumer stalled across two completions
    group(20'h00040, 1'b0);
    chk("t4 Q A", Q, 100'h00045_00044_00043_00042_00041);
    group(20'h00050, 1'b0);
    chk("t4 overrun", {99'b0, overrun}, 100'h1);
    chk("t4 Q held", Q, 100'h00045_00044_00043_00042_00041);
    step(0, 0, 0, 1);
    chk("t4 drained", {99'b0, Q_valid}, '0);
    chk("t4 Q kept", Q, 100'h00045_00044_00043_00042_00041);

    // 5: accept on the same edge a new frame completes
    do_reset();
    group(20'h00060, 1'b0);
    for (int i = 1; i <= 4; i++) step(1, i == 1, 20'h00070 + W'(i), 0);
    step(1, 0, 20'h00075, 1);
    chk("t5 Q_valid", {99'b0, Q_valid}, 100'h1);
    chk("t5 Q", Q, 100'h00075_00074_00073_00072_00071);
    chk("t5 no overrun", {99'b0, overrun}, '0);
    step(0, 0, 0, 1);

    // 6: idle gaps between words, then reset mid-group
    for (int i = 1; i <= N; i++) begin
      int gap = (i == 1) ? 0 : int'($urandom_range(0, 7));
      for (int g = 0; g < gap; g++) step(0, 0, 20'hFFFFF, 1);
      step(1, i == 1, 20'h00080 + W'(i), 1);
    end
    chk("t6 Q", Q, 100'h00085_00084_00083_00082_00081);
    step(1, 1, 20'h00091, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 20'h00092, 0);
    do_reset();
    chk("t6 rst Q", Q, '0);
    chk("t6 rst Q_valid", {99'b0, Q_valid}, '0);
    for (int i = 0; i < 6; i++) step(1, 0, 20'h00099, 1);
    chk("t6 unsync", {99'b0, Q_valid}, '0);
    group(20'h000A0, 1'b1);
    chk("t6 regroup", Q, 100'h000A5_000A4_000A3_000A2_000A1);
    step(0, 0, 0, 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
